// File: rtl/code_checker.sv
// -----------------------------------------------------------------------------
// code_checker
//
// Datapath partner of the lock controller FSM. Collects digit key presses into
// an entry buffer while the controller holds read_input, reports whether the
// buffered length is a legal user code (UC) or programming code (PC) length,
// runs a digit-serial comparison of the buffer against the stored UC, the fixed
// PC or a captured candidate UC, and commits a new UC on store.
//
// Ports:
//   hwclk         in   1  system clock, rising edge
//   rst           in   1  asynchronous active-high reset
//   button        in   4  key code; 7, 8, 9 are commands, all others digits
//   key_strobe    in   1  one-cycle pulse qualifying button
//   read_input    in   1  digit capture enable; rising edge clears the buffer
//   capture       in   1  rising edge copies buffer/length to the candidate
//   store         in   1  rising edge commits a legal candidate as the UC
//   cmp_req       in   1  compare request, held until data_ready is seen
//   cmp_sel       in   2  reference: 0 = UC, 1 = PC, 2 = candidate, 3 = none
//   validLength   out  1  buffer length in [MIN_LEN, MAX_LEN], no overflow
//   validLengthPC out  1  buffer length == PC_LEN, no overflow
//   data_ready    out  1  compare result valid
//   correct_input out  1  compare result, 1 = match
//   digit_count   out  4  current buffer length
// -----------------------------------------------------------------------------
module code_checker #(
    parameter int                   MAX_LEN        = 8,
    parameter int                   MIN_LEN        = 4,
    parameter int                   PC_LEN         = 6,
    parameter logic [4*PC_LEN-1:0]  PC_CODE        = 24'h123456,
    parameter logic [4*MAX_LEN-1:0] DEFAULT_UC     = 32'h00004321,
    parameter int                   DEFAULT_UC_LEN = 4
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic [3:0] button,
    input  logic       key_strobe,
    input  logic       read_input,
    input  logic       capture,
    input  logic       store,
    input  logic       cmp_req,
    input  logic [1:0] cmp_sel,
    output logic       validLength,
    output logic       validLengthPC,
    output logic       data_ready,
    output logic       correct_input,
    output logic [3:0] digit_count
);

    localparam int CNT_W = 4;
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0]   MAX_L  = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0]   MIN_L  = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0]   PC_L   = CNT_W'(PC_LEN);
    localparam logic [CNT_W-1:0]   DEF_L  = CNT_W'(DEFAULT_UC_LEN);
    localparam logic [4*MAX_LEN-1:0] PC_EXT = (4*MAX_LEN)'(PC_CODE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Registered input copies for edge detection
    logic read_q, capture_q, store_q, cmp_req_q;
    logic read_rise, capture_rise, store_rise, cmp_rise;

    // Entry buffer, candidate and stored UC
    logic [3:0]       entry_buf [MAX_LEN];
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic [3:0]       cand_buf  [MAX_LEN];
    logic [CNT_W-1:0] cand_len;
    logic [3:0]       uc_buf    [MAX_LEN];
    logic [CNT_W-1:0] uc_len;
    logic             store_pend;

    // Compare FSM state
    state_t           state, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [CNT_W-1:0] idx, idx_d;
    logic             mism, mism_d;
    logic             data_ready_d, correct_d;

    // Reference selection
    logic [1:0]       ref_sel;
    logic [CNT_W-1:0] ref_len;
    logic [3:0]       ref_digit;
    logic [3:0]       pc_digit;
    logic [IDX_W-1:0] ix;

    logic is_cmd, digit_ok, cand_legal, store_req, store_now;

    assign read_rise    = read_input & ~read_q;
    assign capture_rise = capture    & ~capture_q;
    assign store_rise   = store      & ~store_q;
    assign cmp_rise     = cmp_req    & ~cmp_req_q;

    assign is_cmd   = (button == 4'd7) || (button == 4'd8) || (button == 4'd9);
    // A strobe in the same cycle as the read_input rising edge loses to the clear.
    assign digit_ok = key_strobe & read_input & ~is_cmd & (state == S_IDLE) & ~read_rise;

    assign cand_legal = (cand_len >= MIN_L) && (cand_len <= MAX_L);
    assign store_req  = store_rise | store_pend;
    // Committing while a request is being accepted would let the length check
    // and the digit walk see different codes, so that case is deferred too.
    assign store_now  = store_req && (state == S_IDLE) && !cmp_rise;

    assign validLength   = (count >= MIN_L) && (count <= MAX_L) && !overflow;
    assign validLengthPC = (count == PC_L) && !overflow;
    assign digit_count   = count;

    // -------------------------------------------------------------------------
    // Datapath registers: edge detectors, entry buffer, candidate, stored UC
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values (e.g. capture sees the pre-strobe buffer).
    // NOTE: the digit arrays are reset explicitly because stale digits beyond
    // the count must never leak into a candidate that later becomes the UC.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            read_q     <= 1'b0;
            capture_q  <= 1'b0;
            store_q    <= 1'b0;
            cmp_req_q  <= 1'b0;
            count      <= '0;
            overflow   <= 1'b0;
            cand_len   <= '0;
            uc_len     <= DEF_L;
            store_pend <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                entry_buf[i] <= '0;
                cand_buf[i]  <= '0;
                uc_buf[i]    <= DEFAULT_UC[4*i +: 4];
            end
        end else begin
            read_q    <= read_input;
            capture_q <= capture;
            store_q   <= store;
            cmp_req_q <= cmp_req;

            if (read_rise) begin
                count    <= '0;
                overflow <= 1'b0;
                for (int i = 0; i < MAX_LEN; i++) begin
                    entry_buf[i] <= '0;
                end
            end else if (digit_ok) begin
                if (count < MAX_L) begin
                    entry_buf[count[IDX_W-1:0]] <= button;
                    count                       <= count + 4'd1;
                end else begin
                    overflow <= 1'b1;
                end
            end

            if (capture_rise) begin
                cand_buf <= entry_buf;
                cand_len <= count;
            end

            if (store_now) begin
                store_pend <= 1'b0;
                if (cand_legal) begin
                    uc_buf <= cand_buf;
                    uc_len <= cand_len;
                end
            end else if (store_req) begin
                store_pend <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Reference mux: the live cmp_sel is used for the length check in S_IDLE,
    // the latched selection afterwards.
    // -------------------------------------------------------------------------
    assign ix = idx[IDX_W-1:0];

    // NOTE: every combinationally assigned signal gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    always_comb begin
        pc_digit = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (ix == IDX_W'(i)) pc_digit = PC_EXT[4*i +: 4];
        end
    end

    always_comb begin
        ref_sel   = (state == S_IDLE) ? cmp_sel : sel_q;
        ref_len   = '0;
        ref_digit = '0;
        case (ref_sel)
            2'd0: begin
                ref_len   = uc_len;
                ref_digit = uc_buf[ix];
            end
            2'd1: begin
                ref_len   = PC_L;
                ref_digit = pc_digit;
            end
            2'd2: begin
                ref_len   = cand_len;
                ref_digit = cand_buf[ix];
            end
            default: begin
                ref_len   = '0;
                ref_digit = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Compare FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            sel_q         <= '0;
            idx           <= '0;
            mism          <= 1'b0;
            data_ready    <= 1'b0;
            correct_input <= 1'b0;
        end else begin
            state         <= state_d;
            sel_q         <= sel_d;
            idx           <= idx_d;
            mism          <= mism_d;
            data_ready    <= data_ready_d;
            correct_input <= correct_d;
        end
    end

    // -------------------------------------------------------------------------
    // Compare FSM: next state. A length mismatch (or the reserved selection)
    // is already in mism on the first S_CMP cycle and ends the walk there;
    // digit mismatches do not shorten it, so latency depends only on length.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state;
        sel_d   = sel_q;
        idx_d   = idx;
        mism_d  = mism;
        case (state)
            S_IDLE: begin
                if (cmp_rise) begin
                    sel_d   = cmp_sel;
                    idx_d   = '0;
                    mism_d  = (count != ref_len) || (cmp_sel == 2'd3);
                    state_d = S_CMP;
                end
            end
            S_CMP: begin
                mism_d = mism || (sel_q == 2'd3) ||
                         ((idx < ref_len) && (entry_buf[ix] != ref_digit));
                idx_d  = idx + 4'd1;
                if (((idx == '0) && mism) || (idx_d >= ref_len)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!cmp_req) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Compare FSM: outputs, decoded from the next state and registered above
    // -------------------------------------------------------------------------
    always_comb begin
        data_ready_d = (state_d == S_DONE);
        correct_d    = (state_d == S_DONE) && !mism_d;
    end

endmodule

// File: tb/tb_code_checker.sv
// -----------------------------------------------------------------------------
// tb_code_checker
//
// Self-checking bench for code_checker. Inputs are driven on the falling clock
// edge and outputs sampled there too. Each compare pushes its expected result
// and latency to a scoreboard queue; the entry is popped once data_ready rises.
// -----------------------------------------------------------------------------
module tb_code_checker;

    logic       hwclk = 1'b0;
    logic       rst;
    logic [3:0] button;
    logic       key_strobe;
    logic       read_input;
    logic       capture;
    logic       store;
    logic       cmp_req;
    logic [1:0] cmp_sel;
    logic       validLength;
    logic       validLengthPC;
    logic       data_ready;
    logic       correct_input;
    logic [3:0] digit_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic  match;
        int    lat;
        string tag;
    } exp_t;

    exp_t sb[$];

    code_checker dut (
        .hwclk        (hwclk),
        .rst          (rst),
        .button       (button),
        .key_strobe   (key_strobe),
        .read_input   (read_input),
        .capture      (capture),
        .store        (store),
        .cmp_req      (cmp_req),
        .cmp_sel      (cmp_sel),
        .validLength  (validLength),
        .validLengthPC(validLengthPC),
        .data_ready   (data_ready),
        .correct_input(correct_input),
        .digit_count  (digit_count)
    );

    always #5 hwclk = ~hwclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic strobe(input logic [3:0] d);
        button     = d;
        key_strobe = 1'b1;
        @(negedge hwclk);
        key_strobe = 1'b0;
    endtask

    // Re-arm read_input (clearing the buffer) then enter n digits, first digit
    // in the least significant nibble of digs.
    task automatic enter(input logic [35:0] digs, input int n);
        @(negedge hwclk);
        read_input = 1'b0;
        @(negedge hwclk);
        read_input = 1'b1;
        @(negedge hwclk);
        for (int i = 0; i < n; i++) strobe(digs[4*i +: 4]);
    endtask

    task automatic pulse_capture();
        @(negedge hwclk);
        capture = 1'b1;
        @(negedge hwclk);
        capture = 1'b0;
    endtask

    task automatic pulse_store();
        @(negedge hwclk);
        store = 1'b1;
        @(negedge hwclk);
        store = 1'b0;
        @(negedge hwclk);
    endtask

    // Request a compare; latency counts clocks after the request-detect edge.
    task automatic compare(input logic [1:0] sel, input logic match, input int lat, input string tag);
        exp_t e;
        int   cyc;
        sb.push_back('{match, lat, tag});
        @(negedge hwclk);
        cmp_sel = sel;
        cmp_req = 1'b1;
        cyc = 0;
        do begin
            @(negedge hwclk);
            cyc++;
        end while (!data_ready && cyc < 40);
        e = sb.pop_front();
        check({e.tag, " ready"}, 32'(data_ready), 32'd1);
        check({e.tag, " latency"}, 32'(cyc - 1), 32'(e.lat));
        check({e.tag, " correct"}, 32'(correct_input), 32'(e.match));
        cmp_req = 1'b0;
        @(negedge hwclk);
        check({e.tag, " ready clr"}, 32'(data_ready), 32'd0);
        check({e.tag, " correct clr"}, 32'(correct_input), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        button     = '0;
        key_strobe = 1'b0;
        read_input = 1'b0;
        capture    = 1'b0;
        store      = 1'b0;
        cmp_req    = 1'b0;
        cmp_sel    = '0;
        repeat (2) @(negedge hwclk);
        rst = 1'b0;
        @(negedge hwclk);

        // Reset state
        check("rst data_ready", 32'(data_ready), 32'd0);
        check("rst correct", 32'(correct_input), 32'd0);
        check("rst validLength", 32'(validLength), 32'd0);
        check("rst validLengthPC", 32'(validLengthPC), 32'd0);
        check("rst count", 32'(digit_count), 32'd0);

        // Default UC 1,2,3,4
        enter(36'h4321, 4);
        check("uc4 count", 32'(digit_count), 32'd4);
        check("uc4 validLength", 32'(validLength), 32'd1);
        check("uc4 validLengthPC", 32'(validLengthPC), 32'd0);
        compare(2'd0, 1'b1, 4, "uc 1234");

        // Same length, wrong last digit
        enter(36'h5321, 4);
        compare(2'd0, 1'b0, 4, "uc 1235");

        // Too short
        enter(36'h321, 3);
        check("uc3 validLength", 32'(validLength), 32'd0);
        compare(2'd0, 1'b0, 1, "uc 123");

        // Overflow: nine digits, only eight held
        enter(36'hCBA654321, 9);
        check("ovf count", 32'(digit_count), 32'd8);
        check("ovf validLength", 32'(validLength), 32'd0);
        check("ovf validLengthPC", 32'(validLengthPC), 32'd0);
        enter(36'h0, 0);
        check("rearm count", 32'(digit_count), 32'd0);
        check("rearm validLength", 32'(validLength), 32'd0);

        // Programming code
        enter(36'h123456, 6);
        check("pc6 validLengthPC", 32'(validLengthPC), 32'd1);
        check("pc6 validLength", 32'(validLength), 32'd1);
        compare(2'd1, 1'b1, 6, "pc 654321");
        compare(2'd0, 1'b0, 1, "pc vs uc");
        compare(2'd3, 1'b0, 1, "reserved sel");
        enter(36'h23456, 5);
        check("pc5 validLengthPC", 32'(validLengthPC), 32'd0);
        compare(2'd1, 1'b0, 1, "pc 65432");

        // Store of an illegal (3-digit) candidate is ignored
        enter(36'h987 & 36'h0, 0);
        enter(36'h111, 3);
        pulse_capture();
        pulse_store();
        enter(36'h4321, 4);
        compare(2'd0, 1'b1, 4, "uc kept");

        // Reprogram to 5,5,6,6,0
        enter(36'h06655, 5);
        pulse_capture();
        enter(36'h06655, 5);
        compare(2'd2, 1'b1, 5, "cand match");
        enter(36'h16655, 5);
        compare(2'd2, 1'b0, 5, "cand mismatch");
        pulse_store();
        enter(36'h06655, 5);
        compare(2'd0, 1'b1, 5, "new uc");
        enter(36'h4321, 4);
        compare(2'd0, 1'b0, 1, "old uc");

        // Reset in the middle of a compare
        enter(36'h06655, 5);
        @(negedge hwclk);
        cmp_sel = 2'd0;
        cmp_req = 1'b1;
        repeat (2) @(negedge hwclk);
        rst     = 1'b1;
        cmp_req = 1'b0;
        #1;
        check("midcmp data_ready", 32'(data_ready), 32'd0);
        check("midcmp count", 32'(digit_count), 32'd0);
        @(negedge hwclk);
        rst = 1'b0;
        @(negedge hwclk);
        check("post rst data_ready", 32'(data_ready), 32'd0);
        enter(36'h4321, 4);
        compare(2'd0, 1'b1, 4, "uc reverted");
        enter(36'h06655, 5);
        compare(2'd0, 1'b0, 1, "prog lost");

        // Command codes never enter the buffer
        enter(36'h21, 2);
        strobe(4'd8);
        check("cmd8 count", 32'(digit_count), 32'd2);
        strobe(4'd7);
        strobe(4'd9);
        check("cmd79 count", 32'(digit_count), 32'd2);

        // Strobes with read_input low are ignored
        read_input = 1'b0;
        strobe(4'd3);
        check("ro count", 32'(digit_count), 32'd2);

        // Strobe coinciding with the read_input rising edge is dropped
        read_input = 1'b1;
        strobe(4'd3);
        check("rise drop count", 32'(digit_count), 32'd0);
        strobe(4'd3);
        check("after rise count", 32'(digit_count), 32'd1);

        check("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_checker.md
Name: code_checker

Overview:
- Upstream datapath partner of the lock controller FSM.
- Collects digit presses into an entry buffer while the controller asserts read_input, and reports buffer length validity (validLength, validLengthPC).
- On request, runs a digit-serial comparison of the buffer against the stored user code (UC), the fixed programming code (PC) or a captured candidate UC. Returns data_ready/correct_input.
- Commits a new UC on store.

Parameters:
- MAX_LEN, 8, maximum digits held in entry buffer, candidate and stored UC.
- MIN_LEN, 4, minimum UC length for validLength.
- PC_LEN, 6, programming-code length; validLengthPC requires exactly this count.
- PC_CODE, 24'h123456, PC digits, 4 bits each; digit 0 in the LSB nibble (entry order 6,5,4,3,2,1).
- DEFAULT_UC, 32'h00004321, reset UC digits; digit 0 in the LSB nibble (entry order 1,2,3,4).
- DEFAULT_UC_LEN, 4, reset UC length.

Ports:
- hwclk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- button  in  4  key code; values 7, 8 and 9 are commands, all other values are digits.
- key_strobe  in  1  one-cycle pulse; button is valid in the same cycle.
- read_input  in  1  controller enables digit capture.
- capture  in  1  level; its rising edge copies buffer and length into the candidate register.
- store  in  1  level; its rising edge commits the candidate as the stored UC.
- cmp_req  in  1  level; compare request, held high until data_ready is seen.
- cmp_sel  in  2  compare reference: 0 = stored UC, 1 = PC, 2 = candidate, 3 = reserved (always mismatch).
- validLength  out  1  count in [MIN_LEN, MAX_LEN] and no overflow.
- validLengthPC  out  1  count == PC_LEN and no overflow.
- data_ready  out  1  compare result valid.
- correct_input  out  1  compare result: 1 = match.
- digit_count  out  4  current buffer length, for debug LEDs.

Behaviour:
- Reset (async, rst=1):
  - buffer and count cleared; overflow=0; candidate cleared, candidate length 0.
  - stored UC = DEFAULT_UC, stored length = DEFAULT_UC_LEN.
  - FSM = S_IDLE; all outputs 0.
  - Reset mid-compare aborts the compare with no partial result.
- Edge detect: read_input, capture, store and cmp_req are registered once; rising edges are taken from these registered copies.
- Entry buffer:
  - A rising edge of read_input clears buffer, count and overflow in that cycle.
  - key_strobe with read_input=1, a digit code and FSM in S_IDLE: if count<MAX_LEN, buffer[count]=button and count++. Otherwise set overflow and leave buffer/count unchanged.
  - Command codes 7, 8, 9 never enter the buffer.
  - Strobes while read_input=0 or FSM not in S_IDLE are ignored.
  - If a strobe coincides with the read_input rising edge, the clear wins and the digit is dropped.
  - overflow clears only on reset or a read_input rising edge.
- validLength and validLengthPC are combinational from registered count/overflow.
- Candidate: a capture rising edge copies buffer and count. If capture and a digit strobe share a cycle, the pre-strobe contents are copied.
- Store:
  - A store rising edge copies the candidate into the stored UC, but only if candidate length is in [MIN_LEN, MAX_LEN].
  - Otherwise the store is ignored and the stored UC is kept.
  - A store edge while the FSM is not in S_IDLE is deferred until S_IDLE.
- Compare FSM (S_IDLE, S_CMP, S_DONE):
  - S_IDLE: on the cmp_req rising edge, latch cmp_sel, set idx=0, set mism = (count != ref_len), and go to S_CMP.
  - S_CMP: each cycle, mism |= (buffer[idx] != ref[idx]) and idx++.
    - Go to S_DONE after the compare of idx = ref_len-1.
    - Go to S_DONE after one cycle if mism was already set by the length check.
    - cmp_sel=3 forces mism=1.
  - S_DONE: data_ready=1, correct_input=!mism, both registered. Stay while cmp_req=1; cmp_req=0 → S_IDLE, and data_ready/correct_input clear on the same edge.
  - Latency for a length match of L digits: data_ready is high after the L-th clock following the request-detect edge. Length mismatch: after 1 clock.
  - cmp_req dropping during S_CMP: finish to S_DONE, then return to S_IDLE in the next cycle. No new request is accepted before S_IDLE.
- The stored UC never changes during a compare.

Test Plan:
- Reset, then read_input=1, strobe 1,2,3,4, cmp_sel=0 and cmp_req → validLength=1, data_ready high 4 clocks after detect, correct_input=1.
- Enter 1,2,3,5 then compare with cmp_sel=0 → correct_input=0. Enter 1,2,3 then compare → data_ready after 1 clock, correct_input=0, validLength=0.
- Strobe 9 digits (1..9 skipping 7,8,9: use 1,2,3,4,5,6,10,11,12) → count=8, overflow set, validLength=0. A read_input re-rise then gives count=0, validLength=0.
- PC path: enter 6,5,4,3,2,1 → validLengthPC=1. Compare with cmp_sel=1 → correct_input=1. Enter 6,5,4,3,2 → validLengthPC=0.
- Reprogram: enter 5,5,6,6,0 and capture; re-enter the same digits and compare with cmp_sel=2 → match; pulse store. Now entering 5,5,6,6,0 with cmp_sel=0 matches and 1,2,3,4 does not.
- Assert rst during S_CMP → data_ready=0 and stored UC reverts to 1,2,3,4. Strobe with command code 8 while read_input=1 → count unchanged.
